// File: rtl/grn_pkg.sv
// Shared types and constants for the GRN simulation controller slice.
package grn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT,
    LOAD,
    STEP,
    SAMPLE,
    RESULT
  } grn_state_t;

  // Current sample plus two previous samples must match for a fixed point.
  localparam int unsigned HIST_DEPTH    = 3;
  localparam int unsigned GRN_NUM_NODES = 8;

  typedef logic [GRN_NUM_NODES-1:0] grn_vec_t;

endpackage

// File: rtl/grn_conv_detect.sv
// Snapshot history for fixed-point detection: compares the incoming sample
// against the stored history and shifts it in on request.
module grn_conv_detect
  import grn_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         shift,
  input  logic [W-1:0] cur,
  output logic         converged,
  output logic [W-1:0] last
);

  logic [W-1:0]            hist_q [HIST_DEPTH-1];
  logic [HIST_DEPTH-2:0]   vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < HIST_DEPTH - 1; i++) hist_q[i] <= '0;
      vld_q <= '0;
    end else if (clear) begin
      vld_q <= '0;
    end else if (shift) begin
      hist_q[0] <= cur;
      for (int unsigned i = 1; i < HIST_DEPTH - 1; i++) hist_q[i] <= hist_q[i-1];
      vld_q <= {vld_q[HIST_DEPTH-3:0], 1'b1};
    end
  end

  // Evaluated on the live sample so the decision is available in SAMPLE itself.
  always_comb begin
    converged = &vld_q;
    for (int unsigned i = 0; i < HIST_DEPTH - 1; i++) begin
      if (hist_q[i] != cur) converged = 1'b0;
    end
  end

  assign last = hist_q[0];

endmodule

// File: rtl/grn_sim_ctrl.sv
// Sequencer driving a bank of GRN nodes: load, step, detect fixed point or
// step limit, and return the final state over a valid/ready result port.
module grn_sim_ctrl
  import grn_pkg::*;
#(
  parameter int unsigned NUM_NODES = GRN_NUM_NODES,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     max_steps,
  input  logic                 init_valid,
  output logic                 init_ready,
  input  logic [NUM_NODES-1:0] init_data,
  output logic                 reset_nos,
  output logic [NUM_NODES-1:0] init_state,
  output logic                 start_s0,
  output logic                 start_s1,
  input  logic [NUM_NODES-1:0] ecm_s0,
  input  logic [NUM_NODES-1:0] ecm_s1,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NUM_NODES-1:0] res_s0,
  output logic [NUM_NODES-1:0] res_s1,
  output logic [CNT_W-1:0]     res_steps,
  output logic                 res_converged,
  output logic                 busy,
  output logic                 done
);

  grn_state_t             state_q, state_d;
  logic [CNT_W-1:0]       limit_q;
  logic [CNT_W-1:0]       step_cnt_q;
  logic [NUM_NODES-1:0]   init_q;
  logic                   conv_q;
  logic                   hist_clear, hist_shift, conv;
  logic [2*NUM_NODES-1:0] last;

  grn_conv_detect #(.W(2 * NUM_NODES)) u_conv (
    .clk       (clk),
    .rst       (rst),
    .clear     (hist_clear),
    .shift     (hist_shift),
    .cur       ({ecm_s1, ecm_s0}),
    .converged (conv),
    .last      (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      step_cnt_q <= '0;
      init_q     <= '0;
      conv_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE:      if (start) limit_q <= (max_steps == '0) ? CNT_W'(1) : max_steps;
        WAIT_INIT: if (init_valid) init_q <= init_data;
        LOAD: begin
          step_cnt_q <= '0;
          conv_q     <= 1'b0;
        end
        STEP:      step_cnt_q <= step_cnt_q + 1'b1;
        SAMPLE:    conv_q <= conv;
        default:   ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    init_ready    = 1'b0;
    reset_nos     = 1'b0;
    init_state    = '0;
    start_s0      = 1'b0;
    start_s1      = 1'b0;
    res_valid     = 1'b0;
    res_s0        = '0;
    res_s1        = '0;
    res_steps     = '0;
    res_converged = 1'b0;
    done          = 1'b0;
    hist_clear    = 1'b0;
    hist_shift    = 1'b0;
    busy          = (state_q != IDLE);
    case (state_q)
      IDLE: if (start) state_d = WAIT_INIT;
      WAIT_INIT: begin
        init_ready = 1'b1;
        if (init_valid) state_d = LOAD;
      end
      LOAD: begin
        reset_nos  = 1'b1;
        init_state = init_q;
        hist_clear = 1'b1;
        state_d    = STEP;
      end
      STEP: begin
        start_s0 = 1'b1;
        start_s1 = 1'b1;
        state_d  = SAMPLE;
      end
      SAMPLE: begin
        hist_shift = 1'b1;
        state_d    = (conv || step_cnt_q == limit_q) ? RESULT : STEP;
      end
      RESULT: begin
        res_valid     = 1'b1;
        res_s0        = last[NUM_NODES-1:0];
        res_s1        = last[2*NUM_NODES-1:NUM_NODES];
        res_steps     = step_cnt_q;
        res_converged = conv_q;
        if (res_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_grn_sim_ctrl.sv
// Self-checking bench for grn_sim_ctrl with behavioural node models attached.
module tb_grn_sim_ctrl;
  import grn_pkg::*;

  localparam int M_HOLD  = 0;
  localparam int M_TOG   = 1;
  localparam int M_DECAY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] max_steps = '0;
  logic        init_valid = 1'b0;
  logic        init_ready;
  grn_vec_t    init_data = '0;
  logic        reset_nos;
  grn_vec_t    init_state;
  logic        start_s0, start_s1;
  grn_vec_t    ecm_s0, ecm_s1;
  logic        res_valid;
  logic        res_ready = 1'b0;
  grn_vec_t    res_s0, res_s1;
  logic [15:0] res_steps;
  logic        res_converged, busy, done;

  int checks = 0;
  int failures = 0;
  int node_mode = M_HOLD;
  int node_k = 0;
  int step_tot = 0;
  int nos_tot = 0;
  grn_vec_t nos_val = '0;
  grn_vec_t n0 = '0, n1 = '0;

  grn_sim_ctrl #(.NUM_NODES(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .max_steps(max_steps),
    .init_valid(init_valid), .init_ready(init_ready), .init_data(init_data),
    .reset_nos(reset_nos), .init_state(init_state),
    .start_s0(start_s0), .start_s1(start_s1),
    .ecm_s0(ecm_s0), .ecm_s1(ecm_s1),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_s0(res_s0), .res_s1(res_s1), .res_steps(res_steps),
    .res_converged(res_converged), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Node update rule; k is the 1-based step index since the last load.
  function automatic void node_next(input int mode, input int k,
                                    inout grn_vec_t s0, inout grn_vec_t s1);
    case (mode)
      M_TOG: begin s0 = ~s0; s1 = ~s1; end
      M_DECAY: begin
        s1 = s1 & s0;
        if (k % 2 == 0) s0 = s0 & {s0[6:0], 1'b0};
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk) begin : nodes
    grn_vec_t t0, t1;
    if (reset_nos) begin
      n0 <= init_state; n1 <= init_state; node_k <= 0;
    end else if (start_s0) begin
      t0 = n0; t1 = n1;
      node_next(node_mode, node_k + 1, t0, t1);
      n0 <= t0; n1 <= t1; node_k <= node_k + 1;
    end
  end
  assign ecm_s0 = n0;
  assign ecm_s1 = n1;

  always @(negedge clk) begin
    if (reset_nos) begin nos_tot++; nos_val = init_state; end
    if (start_s0) step_tot++;
  end

  // Reference: run the sample sequence, stop on three equal samples or the limit.
  function automatic void model(input int mode, input int maxs, input grn_vec_t init,
                                output int steps, output bit conv,
                                output grn_vec_t r0, output grn_vec_t r1);
    int lim;
    logic [15:0] h[$];
    grn_vec_t s0, s1;
    lim = (maxs == 0) ? 1 : maxs;
    s0 = init; s1 = init; conv = 0; steps = 0;
    for (int k = 1; k <= lim; k++) begin
      node_next(mode, k, s0, s1);
      h.push_back({s1, s0});
      steps = k;
      if (h.size() >= 3 && h[h.size()-1] == h[h.size()-2] && h[h.size()-2] == h[h.size()-3]) begin
        conv = 1;
        break;
      end
    end
    r0 = s0; r1 = s1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run(input int mode, input int maxs, input grn_vec_t init,
                     input int e_steps, input bit e_conv, input grn_vec_t e0, input grn_vec_t e1,
                     input int hold, input bit poke);
    int b_steps, b_nos;
    bit poked, got;
    node_mode = mode;
    b_steps = step_tot;
    b_nos = nos_tot;
    if (poke) begin
      init_valid = 1'b1; init_data = 8'hFF;
      @(negedge clk);
      chk("init_ready_idle", init_ready, 0);
      @(negedge clk);
      init_valid = 1'b0;
    end
    chk("busy_idle", busy, 0);
    start = 1'b1; max_steps = maxs[15:0];
    @(negedge clk);
    start = 1'b0;
    chk("init_ready_wait", init_ready, 1);
    chk("busy_wait", busy, 1);
    init_valid = 1'b1; init_data = init;
    @(negedge clk);
    init_valid = 1'b0; init_data = '0;
    chk("init_ready_load", init_ready, 0);
    got = 0; poked = 0;
    for (int n = 0; n < 300; n++) begin
      if (res_valid) begin got = 1; break; end
      if (start) start = 1'b0;
      if (poke && !poked && start_s0) begin
        start = 1'b1; poked = 1;
        chk("init_ready_busy", init_ready, 0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!got) begin
      chk("res_timeout", 0, 1);
      return;
    end
    chk("res_s0", res_s0, e0);
    chk("res_s1", res_s1, e1);
    chk("res_steps", res_steps, e_steps);
    chk("res_conv", res_converged, e_conv);
    chk("step_pulses", step_tot - b_steps, e_steps);
    chk("nos_pulses", nos_tot - b_nos, 1);
    chk("nos_init", nos_val, init);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_s0", res_s0, e0);
      chk("hold_s1", res_s1, e1);
      chk("hold_steps", res_steps, e_steps);
      chk("hold_conv", res_converged, e_conv);
      chk("hold_done", done, 0);
    end
    res_ready = 1'b1;
    #1;
    chk("done_pulse", done, 1);
    @(negedge clk);
    res_ready = 1'b0;
    chk("done_clear", done, 0);
    chk("busy_after", busy, 0);
    chk("valid_after", res_valid, 0);
    chk("extra_steps", step_tot - b_steps, e_steps);
  endtask

  typedef struct {
    int       mode;
    int       maxs;
    grn_vec_t init;
    int       e_steps;
    bit       e_conv;
    grn_vec_t e0;
    grn_vec_t e1;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int n, mode, maxs, es;
    bit ec;
    grn_vec_t iv, e0, e1;

    tbl[0] = '{M_HOLD, 10, 8'hA5, 3, 1'b1, 8'hA5, 8'hA5};
    tbl[1] = '{M_TOG,  10, 8'hA5, 10, 1'b0, 8'hA5, 8'hA5};
    tbl[2] = '{M_HOLD, 0,  8'hA5, 1, 1'b0, 8'hA5, 8'hA5};
    tbl[3] = '{M_HOLD, 2,  8'h11, 2, 1'b0, 8'h11, 8'h11};
    tbl[4] = '{M_HOLD, 3,  8'h42, 3, 1'b1, 8'h42, 8'h42};
    tbl[5] = '{M_TOG,  1,  8'h0F, 1, 1'b0, 8'hF0, 8'hF0};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_init_ready", init_ready, 0);
    chk("rst_reset_nos", reset_nos, 0);
    chk("rst_init_state", init_state, 0);
    chk("rst_strobes", {start_s0, start_s1}, 0);
    chk("rst_res", {res_valid, res_converged, done, res_s0, res_s1}, 0);
    chk("rst_steps", res_steps, 0);
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl[i])
      run(tbl[i].mode, tbl[i].maxs, tbl[i].init, tbl[i].e_steps, tbl[i].e_conv,
          tbl[i].e0, tbl[i].e1, 0, 1'b0);

    run(M_HOLD, 10, 8'hA5, 3, 1'b1, 8'hA5, 8'hA5, 5, 1'b0);
    run(M_HOLD, 10, 8'hA5, 3, 1'b1, 8'hA5, 8'hA5, 0, 1'b1);

    // Abort during the 4th SAMPLE of a 10-step run.
    node_mode = M_TOG;
    start = 1'b1; max_steps = 16'd10;
    @(negedge clk);
    start = 1'b0; init_valid = 1'b1; init_data = 8'h55;
    @(negedge clk);
    init_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      if (start_s0) n++;
      @(negedge clk);
    end
    chk("abort_reached", n, 4);
    chk("abort_busy_pre", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_strobes", {start_s0, start_s1, reset_nos}, 0);
    chk("abort_res", {res_valid, done, init_ready}, 0);
    chk("abort_init_state", init_state, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_idle", {busy, res_valid}, 0);
    run(M_HOLD, 10, 8'h3C, 3, 1'b1, 8'h3C, 8'h3C, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      mode = $urandom_range(0, 2);
      maxs = $urandom_range(0, 20);
      iv = grn_vec_t'($urandom);
      model(mode, maxs, iv, es, ec, e0, e1);
      run(mode, maxs, iv, es, ec, e0, e1, $urandom_range(0, 3), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grn_sim_ctrl.md
Name: grn_sim_ctrl

Overview:
- Sequencer that drives a bank of NUM_NODES GRN node instances from the controlling side of the node interface.
- Drives reset_nos, init_state, start_s0 and start_s1 into the nodes, and reads their ecm_s0/ecm_s1 state back.
- Loads an initial state vector, steps the network, and detects a fixed point (or a step limit).
- Returns the final state and step count over a valid/ready result port. Sits between the host-side stream logic and the node array.

Parameters:
- NUM_NODES, 8, number of nodes driven; width of all state vectors.
- CNT_W, 16, width of the step counter, max_steps and res_steps.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; ignored unless IDLE.
- max_steps  in  CNT_W  step limit, sampled on accepted start.
- init_valid  in  1  initial vector valid.
- init_ready  out  1  controller ready for initial vector.
- init_data  in  NUM_NODES  initial state, bit i goes to node i.
- reset_nos  out  1  node load strobe.
- init_state  out  NUM_NODES  per-node initial state, valid with reset_nos.
- start_s0  out  1  node s0 step strobe.
- start_s1  out  1  node s1 step strobe.
- ecm_s0  in  NUM_NODES  node s0 states.
- ecm_s1  in  NUM_NODES  node s1 states.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_s0  out  NUM_NODES  final s0 snapshot.
- res_s1  out  NUM_NODES  final s1 snapshot.
- res_steps  out  CNT_W  steps executed.
- res_converged  out  1  1 means fixed point found.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on result handshake.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE, all counters and snapshots clear, every output is 0.
- Reset asserted mid-run aborts the run: no result is produced and strobes drop immediately.
- FSM states and transitions:
  - IDLE -> WAIT_INIT on start=1. Latch limit = (max_steps==0 ? 1 : max_steps).
  - WAIT_INIT: init_ready=1. When init_valid&&init_ready, latch init_data -> LOAD.
  - LOAD, 1 cycle: reset_nos=1, init_state=latched vector. Clear step counter and history valid bits -> STEP.
  - STEP, 1 cycle: start_s0=1 and start_s1=1. Step counter +1 -> SAMPLE.
  - SAMPLE, 1 cycle: capture cur={ecm_s1,ecm_s0}. Shift history prev2<=prev1, prev1<=cur.
    - converged = (cur==prev1) && (prev1==prev2), with both history entries valid.
    - If converged or counter==limit -> RESULT, else -> STEP.
  - RESULT: res_valid=1 with res_s0, res_s1, res_steps, res_converged held stable. On res_ready -> IDLE, done=1 on that cycle.
- Step timing:
  - 2 clocks per step.
  - init_state and reset_nos are 0 outside LOAD; strobes are 0 outside LOAD/STEP.
  - The nodes register their state on the STEP edge, so ecm_* is sampled in SAMPLE.
- Convergence rules:
  - Three identical consecutive samples are required, because nodes advance s0 only on every second start_s0.
  - Earliest convergence is therefore step 3. With limit<3, res_converged is always 0.
- Simultaneous events:
  - Convergence and limit on the same sample: res_converged=1.
  - start while busy: ignored.
  - init_valid outside WAIT_INIT: ignored, init_ready stays 0.
- Counter: saturation is never reached, since the limit is at most 2^CNT_W-1.
- res_steps: equals the number of STEP cycles issued.
- Result backpressure: res_valid stays high indefinitely until res_ready. Outputs do not change while held.

Decomposition:
- Shared package grn_pkg holds:
  - state enum (IDLE, WAIT_INIT, LOAD, STEP, SAMPLE, RESULT);
  - localparam for the history depth (3);
  - a typedef for the state vector width.
- One sub-module, grn_conv_detect:
  - holds the snapshot history (cur/prev1/prev2 plus valid bits);
  - has clear and shift inputs;
  - outputs the converged flag.
- The FSM and counters stay in grn_sim_ctrl.

Test Plan:
1. Hold-state node models, max_steps=10, init 0xA5 -> reset_nos pulse with init_state=0xA5, 3 STEP pulses; res_s0=res_s1=0xA5, res_steps=3, res_converged=1.
2. Toggling node models (invert each step), max_steps=10 -> exactly 10 STEP pulses; res_converged=0, res_steps=10.
3. max_steps=0, hold models -> exactly 1 step; res_steps=1, res_converged=0.
4. Result backpressure: res_ready low for 5 cycles after res_valid -> res_valid and data stable for 5 cycles; done pulses once on acceptance; busy falls the next cycle.
5. start pulsed during STEP, and init_valid high in IDLE -> no effect; init_ready=0 outside WAIT_INIT; the run completes identically to scenario 1.
6. rst low during the 4th SAMPLE of a 10-step run -> all outputs 0 asynchronously; IDLE afterwards; a fresh start with init 0x3C completes normally with res_steps=3.
